main_dec: RTL and testbench

// - Main control decoder for the single-cycle LEGv8 datapath.
// - Decodes the 11-bit opcode field (Instr[31:21]) into datapath control signals and a 2-bit ALUOp for the ALU decoder.
// - Outputs are registered: one pipeline register between fetch/decode and execute control.

---
 rtl/leg_pkg.sv | 36 +++
 rtl/main_dec_comb.sv | 50 +++++
 rtl/main_dec.sv | 57 +++++
 tb/tb_main_dec.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/leg_pkg.sv
// ==========================================================================
// leg_pkg: shared opcode constants and control-word types for LEGv8 decode
// Rev 1.0
// ==========================================================================
`default_nettype none

package leg_pkg;

  localparam logic [10:0] OP_LDUR     = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR     = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ_MSB8 = 8'b1011_0100;
  localparam logic [10:0] OP_ADD      = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB      = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND      = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR      = 11'b101_0101_0000;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic    reg2loc;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/main_dec_comb.sv
// ==========================================================================
// main_dec_comb: combinational opcode -> control word decode
// Rev 1.0
// ==========================================================================
`default_nettype none

module main_dec_comb
  import leg_pkg::*;
(
  input  logic [10:0] op,
  output ctrl_t       ctrl,
  output logic        illegal
);

  // CBZ ignores Op[2:0]; the range arm covers all eight encodings and an
  // X/Z opcode matches no arm, falling to the all-zero default.
  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALUOP_MEM;
    illegal      = 1'b0;
    unique case (op) inside
      OP_LDUR: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_STUR: begin
        ctrl.reg2loc   = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      [{OP_CBZ_MSB8, 3'b000}:{OP_CBZ_MSB8, 3'b111}]: begin
        ctrl.reg2loc = 1'b1;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_BR;
      end
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/main_dec.sv
// ==========================================================================
// main_dec: LEGv8 main control decoder with one registered output stage
// Rev 1.0
// ==========================================================================
`default_nettype none

module main_dec
  import leg_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] Op,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        Illegal
);

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  ctrl_t ctrl_held;
  logic  illegal_held;

  main_dec_comb u_comb (
    .op      (Op),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_held    <= '0;
      illegal_held <= 1'b0;
    end else begin
      ctrl_held    <= dec_ctrl;
      illegal_held <= dec_illegal;
    end
  end

  assign Reg2Loc  = ctrl_held.reg2loc;
  assign ALUSrc   = ctrl_held.alu_src;
  assign MemtoReg = ctrl_held.mem_to_reg;
  assign RegWrite = ctrl_held.reg_write;
  assign MemRead  = ctrl_held.mem_read;
  assign MemWrite = ctrl_held.mem_write;
  assign Branch   = ctrl_held.branch;
  assign ALUOp    = ctrl_held.alu_op;
  assign Illegal  = illegal_held;

endmodule

`default_nettype wire

// File: tb/tb_main_dec.sv
// ==========================================================================
// tb_main_dec: randomized self-checking bench for main_dec
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_main_dec;

  logic        clk;
  logic        reset_n;
  logic [10:0] Op;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Illegal;
  logic [1:0]  ALUOp;

  int checks   = 0;
  int failures = 0;

  string fname [10] = '{"Illegal", "ALUOp[0]", "ALUOp[1]", "Branch", "MemWrite",
                        "MemRead", "RegWrite", "MemtoReg", "ALUSrc", "Reg2Loc"};

  main_dec dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Op       (Op),
    .Reg2Loc  (Reg2Loc),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0] Illegal
  function automatic logic [9:0] model(input logic [10:0] o);
    if (o == 11'h7C2)                     return 10'b0111100_00_0; // LDUR
    else if (o == 11'h7C0)                return 10'b1100010_00_0; // STUR
    else if ((o >> 3) == 11'h0B4)         return 10'b1000001_01_0; // CBZ
    else if (o == 11'h458 || o == 11'h658 ||
             o == 11'h450 || o == 11'h550) return 10'b0001000_10_0; // R-type
    else                                  return 10'b0000000_00_1;
  endfunction

  function automatic logic [9:0] observed();
    return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal};
  endfunction

  // Drive Op, let one rising edge capture it, sample 1 time unit later.
  task automatic step(input logic [10:0] v);
    Op = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset_n = 1'b0;
    Op = 11'h7C2;
    repeat (3) @(posedge clk);
    #1;
    obs = observed();
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs[b] !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold %s: got %b want 0", fname[b], obs[b]);
      end
    end
    reset_n = 1'b1;
    #2;
    obs = observed();
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs[b] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release %s: got %b want 0", fname[b], obs[b]);
      end
    end
    step(11'h7C2);
    obs = observed();
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs[b] !== model(11'h7C2) [b]) begin
        failures++;
        $display("FAIL reset_first_ldur %s: got %b want %b", fname[b], obs[b], model(11'h7C2) [b]);
      end
    end
  endtask

  task automatic test_stur();
    logic [9:0] obs, exp;
    step(11'h7C0);
    obs = observed();
    exp = 10'b1100010_00_0;
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs[b] !== exp[b]) begin
        failures++;
        $display("FAIL stur %s: got %b want %b", fname[b], obs[b], exp[b]);
      end
    end
  endtask

  task automatic test_cbz_sweep();
    logic [9:0]  obs, exp;
    logic [10:0] v;
    for (int k = 0; k < 9; k++) begin
      v = 11'h5A0 + 11'(k);
      step(v);
      obs = observed();
      exp = (k < 8) ? 10'b1000001_01_0 : 10'b0000000_00_1;
      for (int b = 0; b < 10; b++) begin
        checks++;
        if (obs[b] !== exp[b]) begin
          failures++;
          $display("FAIL cbz_sweep op=%b %s: got %b want %b", v, fname[b], obs[b], exp[b]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [4] = '{11'h458, 11'h658, 11'h450, 11'h550};
    logic [9:0]  obs;
    for (int k = 0; k < 4; k++) begin
      step(ops[k]);
      obs = observed();
      for (int b = 0; b < 10; b++) begin
        checks++;
        if (obs[b] !== model(ops[k]) [b]) begin
          failures++;
          $display("FAIL rtype op=%b %s: got %b want %b", ops[k], fname[b], obs[b], model(ops[k]) [b]);
        end
      end
    end
  endtask

  task automatic test_default();
    logic [10:0] ops [2] = '{11'h00F, 11'h7FF};
    logic [9:0]  obs, exp;
    exp = 10'b0000000_00_1;
    for (int k = 0; k < 2; k++) begin
      step(ops[k]);
      obs = observed();
      for (int b = 0; b < 10; b++) begin
        checks++;
        if (obs[b] !== exp[b]) begin
          failures++;
          $display("FAIL default op=%b %s: got %b want %b", ops[k], fname[b], obs[b], exp[b]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] legal [7] = '{11'h7C2, 11'h7C0, 11'h5A0, 11'h458, 11'h658, 11'h450, 11'h550};
    logic [10:0] v;
    logic [9:0]  obs;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) v = 11'($urandom);
      else begin
        v = legal[$urandom_range(0, 6)];
        if (v == 11'h5A0) v = v | 11'($urandom_range(0, 7));
      end
      step(v);
      obs = observed();
      for (int b = 0; b < 10; b++) begin
        checks++;
        if (obs[b] !== model(v) [b]) begin
          failures++;
          $display("FAIL random op=%b %s: got %b want %b", v, fname[b], obs[b], model(v) [b]);
        end
      end
      checks++;
      if ((MemRead & MemWrite) !== 1'b0) begin
        failures++;
        $display("FAIL rw_exclusive op=%b: got %b want 0", v, MemRead & MemWrite);
      end
      checks++;
      if ((Branch & RegWrite) !== 1'b0) begin
        failures++;
        $display("FAIL branch_nowrite op=%b: got %b want 0", v, Branch & RegWrite);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] obs;
    step(11'h7C2);
    #2;
    reset_n = 1'b0;
    #1;
    obs = observed();
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs[b] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset %s: got %b want 0", fname[b], obs[b]);
      end
    end
    #2;
    reset_n = 1'b1;
    step(11'h7C0);
    obs = observed();
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs[b] !== model(11'h7C0) [b]) begin
        failures++;
        $display("FAIL post_async_stur %s: got %b want %b", fname[b], obs[b], model(11'h7C0) [b]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    Op      = '0;
    test_reset();
    test_stur();
    test_cbz_sweep();
    test_back_to_back();
    test_default();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
